// File: rtl/uart_baud_ctrl_if.sv
// Configuration handshake between a baud-rate requester and uart_baud_ctrl.
// The master proposes a terminal count; the controller reports readiness and clamping.
interface uart_baud_ctrl_if;
    localparam int unsigned PERIOD_W = 32;

    logic                cfg_valid;
    logic [PERIOD_W-1:0] cfg_period;
    logic                cfg_ready;
    logic                cfg_clamped;

    modport master (
        output cfg_valid,
        output cfg_period,
        input  cfg_ready,
        input  cfg_clamped
    );

    modport slave (
        input  cfg_valid,
        input  cfg_period,
        output cfg_ready,
        output cfg_clamped
    );
endinterface

// File: rtl/uart_baud_ctrl.sv
// UART baud divider with glitch-free period switching: a new terminal count is
// held pending and only takes effect on an idle terminal cycle or while parked.
module uart_baud_ctrl #(
    parameter logic [31:0] DEFAULT_PERIOD = 32'd103,
    parameter logic [31:0] MIN_PERIOD     = 32'd1
) (
    input  logic                   hwclk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   busy,
    uart_baud_ctrl_if.slave        cfg,
    output logic                   tick,
    output logic                   clk_out,
    output logic [31:0]            cur_period,
    output logic                   switch_done
);
    localparam int unsigned PERIOD_W = 32;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t              state;
    state_t              state_d;
    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] cnt_d;
    logic [PERIOD_W-1:0] pend_period;
    logic [PERIOD_W-1:0] pend_period_d;
    logic [PERIOD_W-1:0] cur_period_d;
    logic                tick_d;
    logic                clk_out_d;
    logic                switch_done_d;
    logic                clamped_d;
    logic                ready_d;
    logic                terminal;
    logic                too_small;

    assign terminal  = (cnt == cur_period);
    assign too_small = (cfg.cfg_period < MIN_PERIOD);

    // Divider datapath plus RUN/PEND request handling.
    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        pend_period_d = pend_period;
        cur_period_d  = cur_period;
        tick_d        = 1'b0;
        clk_out_d     = clk_out;
        switch_done_d = 1'b0;
        clamped_d     = 1'b0;

        if (!en) begin
            cnt_d     = '0;
            clk_out_d = 1'b0;
        end else if (terminal) begin
            cnt_d     = '0;
            clk_out_d = ~clk_out;
            tick_d    = 1'b1;
        end else begin
            cnt_d = cnt + PERIOD_W'(1);
        end

        if (state == ST_RUN) begin
            if (cfg.cfg_valid) begin
                pend_period_d = too_small ? MIN_PERIOD : cfg.cfg_period;
                clamped_d     = too_small;
                state_d       = ST_PEND;
            end
        end else begin
            // Parked divider switches at once; a running one waits for an idle terminal.
            if (!en) begin
                cur_period_d  = pend_period;
                switch_done_d = 1'b1;
                state_d       = ST_RUN;
            end else if (terminal && !busy) begin
                cur_period_d  = pend_period;
                clk_out_d     = 1'b0;
                switch_done_d = 1'b1;
                state_d       = ST_RUN;
            end
        end

        ready_d = (state_d == ST_RUN);
    end

    always_ff @(posedge hwclk) begin
        if (reset) begin
            state           <= ST_RUN;
            cnt             <= '0;
            pend_period     <= '0;
            cur_period      <= DEFAULT_PERIOD;
            tick            <= 1'b0;
            clk_out         <= 1'b0;
            switch_done     <= 1'b0;
            cfg.cfg_clamped <= 1'b0;
            cfg.cfg_ready   <= 1'b1;
        end else begin
            state           <= state_d;
            cnt             <= cnt_d;
            pend_period     <= pend_period_d;
            cur_period      <= cur_period_d;
            tick            <= tick_d;
            clk_out         <= clk_out_d;
            switch_done     <= switch_done_d;
            cfg.cfg_clamped <= clamped_d;
            cfg.cfg_ready   <= ready_d;
        end
    end
endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Bench for uart_baud_ctrl: directed scenarios plus random traffic, checked
// cycle by cycle against a phase/arithmetic model of the divider.
module tb_uart_baud_ctrl;
    localparam logic [31:0] DEF_P = 32'd103;
    localparam logic [31:0] MIN_P = 32'd1;

    logic        hwclk = 1'b0;
    logic        reset;
    logic        en;
    logic        busy;
    logic        tick;
    logic        clk_out;
    logic [31:0] cur_period;
    logic        switch_done;

    uart_baud_ctrl_if cfg_if ();

    uart_baud_ctrl #(.DEFAULT_PERIOD(DEF_P), .MIN_PERIOD(MIN_P)) dut (
        .hwclk       (hwclk),
        .reset       (reset),
        .en          (en),
        .busy        (busy),
        .cfg         (cfg_if),
        .tick        (tick),
        .clk_out     (clk_out),
        .cur_period  (cur_period),
        .switch_done (switch_done)
    );

    always #5 hwclk = ~hwclk;

    wire [36:0] obs = {tick, clk_out, switch_done, cfg_if.cfg_ready, cfg_if.cfg_clamped, cur_period};

    int     n_cmp = 0;
    int     n_err = 0;
    longint cyc   = 0;

    // Model: period in force, cycle at which the current phase began, pending request.
    longint     m_per  = 103;
    longint     m_base = 0;
    bit         m_pend = 1'b0;
    longint     m_pval = 0;
    logic [36:0] expv;

    // Advance one clock; expv holds what the outputs must show after the edge.
    task automatic cycle();
        bit     ntick;
        bit     nclk;
        bit     nsd;
        bit     ncl;
        bit     term;
        bit     was_pend;
        longint age;
        longint req;
        ntick = 1'b0; nclk = 1'b0; nsd = 1'b0; ncl = 1'b0;
        if (reset) begin
            m_per  = longint'(DEF_P);
            m_pend = 1'b0;
            m_pval = 0;
            m_base = cyc + 1;
        end else begin
            was_pend = m_pend;
            age  = cyc - m_base;
            term = en && ((age % (m_per + 1)) == m_per);
            if (was_pend && !en) begin
                m_per = m_pval; m_pend = 1'b0; nsd = 1'b1; m_base = cyc + 1;
            end else if (was_pend && term && !busy) begin
                ntick = 1'b1; m_per = m_pval; m_pend = 1'b0; nsd = 1'b1; m_base = cyc + 1;
            end else if (!en) begin
                m_base = cyc + 1;
            end else begin
                ntick = term;
                nclk  = bit'(((cyc + 1 - m_base) / (m_per + 1)) % 2);
            end
            if (!was_pend && cfg_if.cfg_valid) begin
                req    = longint'(cfg_if.cfg_period);
                m_pend = 1'b1;
                m_pval = (req < longint'(MIN_P)) ? longint'(MIN_P) : req;
                ncl    = (req < longint'(MIN_P));
            end
        end
        expv = {ntick, nclk, nsd, ~m_pend, ncl, 32'(m_per)};
        @(posedge hwclk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b0; busy = 1'b0;
        cfg_if.cfg_valid = 1'b0; cfg_if.cfg_period = '0;
        repeat (3) begin
            cycle();
            n_cmp++;
            if (obs !== expv) begin n_err++; $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, obs, expv); end
        end
        reset = 1'b0;
        n_cmp++;
        if ({cur_period, cfg_if.cfg_ready, tick, clk_out, switch_done} !== {DEF_P, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL reset_state got per=%0d rdy=%b tick=%b clk=%b sd=%b", cur_period, cfg_if.cfg_ready, tick, clk_out, switch_done);
        end
    endtask

    task automatic test_default_rate();
        longint last = -1;
        int     hi   = 0;
        logic   prev = 1'b0;
        en = 1'b1;
        repeat (420) begin
            cycle();
            n_cmp++;
            if (obs !== expv) begin n_err++; $display("FAIL default_rate cyc=%0d got=%h exp=%h", cyc, obs, expv); end
            if (tick === 1'b1) begin
                if (last >= 0) begin
                    n_cmp++;
                    if (cyc - last != 104) begin n_err++; $display("FAIL default_spacing got=%0d exp=104", cyc - last); end
                end
                last = cyc;
            end
            if (prev === 1'b1 && clk_out === 1'b0) begin
                n_cmp++;
                if (hi != 104) begin n_err++; $display("FAIL default_high got=%0d exp=104", hi); end
                hi = 0;
            end
            if (clk_out === 1'b1) hi++;
            prev = clk_out;
        end
    endtask

    task automatic test_switch_idle();
        bit     seen = 1'b0;
        longint last = -1;
        busy = 1'b0;
        repeat (30) begin
            cycle();
            n_cmp++;
            if (obs !== expv) begin n_err++; $display("FAIL switch_pre cyc=%0d got=%h exp=%h", cyc, obs, expv); end
        end
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_period = 32'd9;
        cycle();
        cfg_if.cfg_valid = 1'b0;
        n_cmp++;
        if (cfg_if.cfg_ready !== 1'b0) begin n_err++; $display("FAIL switch_ready_low got=%b exp=0", cfg_if.cfg_ready); end
        for (int i = 0; i < 200 && !seen; i++) begin
            cycle();
            n_cmp++;
            if (obs !== expv) begin n_err++; $display("FAIL switch_wait cyc=%0d got=%h exp=%h", cyc, obs, expv); end
            if (switch_done === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen || cur_period !== 32'd9 || clk_out !== 1'b0 || tick !== 1'b1) begin
            n_err++; $display("FAIL switch_event got seen=%b per=%0d clk=%b tick=%b exp 1/9/0/1", seen, cur_period, clk_out, tick);
        end
        last = cyc;
        repeat (40) begin
            cycle();
            n_cmp++;
            if (obs !== expv) begin n_err++; $display("FAIL switch_post cyc=%0d got=%h exp=%h", cyc, obs, expv); end
            if (tick === 1'b1) begin
                n_cmp++;
                if (cyc - last != 10) begin n_err++; $display("FAIL switch_spacing got=%0d exp=10", cyc - last); end
                last = cyc;
            end
        end
    endtask

    task automatic test_busy_block();
        int sd_cnt = 0;
        int ticks  = 0;
        bit seen   = 1'b0;
        busy = 1'b1;
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_period = 32'd4;
        cycle();
        cfg_if.cfg_valid = 1'b0;
        for (int i = 0; i < 35; i++) begin
            cfg_if.cfg_valid = (i == 12); cfg_if.cfg_period = 32'd50;
            cycle();
            n_cmp++;
            if (obs !== expv) begin n_err++; $display("FAIL busy_hold cyc=%0d got=%h exp=%h", cyc, obs, expv); end
            if (switch_done === 1'b1) sd_cnt++;
            if (tick === 1'b1) ticks++;
        end
        cfg_if.cfg_valid = 1'b0;
        n_cmp++;
        if (sd_cnt != 0 || ticks < 3 || cur_period !== 32'd9) begin
            n_err++; $display("FAIL busy_blocked got sd=%0d ticks=%0d per=%0d exp 0/>=3/9", sd_cnt, ticks, cur_period);
        end
        busy = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle();
            n_cmp++;
            if (obs !== expv) begin n_err++; $display("FAIL busy_release cyc=%0d got=%h exp=%h", cyc, obs, expv); end
            if (switch_done === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen || cur_period !== 32'd4) begin n_err++; $display("FAIL busy_switch got seen=%b per=%0d exp 1/4", seen, cur_period); end
    endtask

    task automatic test_clamp();
        bit seen  = 1'b0;
        int ticks = 0;
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_period = 32'd0;
        cycle();
        cfg_if.cfg_valid = 1'b0;
        n_cmp++;
        if (cfg_if.cfg_clamped !== 1'b1) begin n_err++; $display("FAIL clamp_pulse got=%b exp=1", cfg_if.cfg_clamped); end
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle();
            n_cmp++;
            if (obs !== expv) begin n_err++; $display("FAIL clamp_wait cyc=%0d got=%h exp=%h", cyc, obs, expv); end
            if (switch_done === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen || cur_period !== 32'd1) begin n_err++; $display("FAIL clamp_period got seen=%b per=%0d exp 1/1", seen, cur_period); end
        repeat (12) begin
            cycle();
            n_cmp++;
            if (obs !== expv) begin n_err++; $display("FAIL clamp_run cyc=%0d got=%h exp=%h", cyc, obs, expv); end
            if (tick === 1'b1) ticks++;
        end
        n_cmp++;
        if (ticks != 6) begin n_err++; $display("FAIL clamp_ticks got=%0d exp=6", ticks); end
    endtask

    task automatic test_en_low();
        int  n    = 0;
        bit  seen = 1'b0;
        en = 1'b0; busy = 1'b1;
        cycle();
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_period = 32'd20;
        cycle();
        cfg_if.cfg_valid = 1'b0;
        cycle();
        n_cmp++;
        if (obs !== expv) begin n_err++; $display("FAIL enlow_switch cyc=%0d got=%h exp=%h", cyc, obs, expv); end
        n_cmp++;
        if (switch_done !== 1'b1 || tick !== 1'b0 || cur_period !== 32'd20) begin
            n_err++; $display("FAIL enlow_event got sd=%b tick=%b per=%0d exp 1/0/20", switch_done, tick, cur_period);
        end
        en = 1'b1; busy = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            cycle();
            n++;
            n_cmp++;
            if (obs !== expv) begin n_err++; $display("FAIL enlow_run cyc=%0d got=%h exp=%h", cyc, obs, expv); end
            if (tick === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen || n != 21) begin n_err++; $display("FAIL enlow_first_tick got=%0d exp=21", n); end
    endtask

    task automatic test_reset_pend();
        int sd_cnt = 0;
        en = 1'b1; busy = 1'b1;
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_period = 32'd7;
        cycle();
        cfg_if.cfg_valid = 1'b0;
        repeat (5) cycle();
        n_cmp++;
        if (cfg_if.cfg_ready !== 1'b0) begin n_err++; $display("FAIL rstpend_ready_low got=%b exp=0", cfg_if.cfg_ready); end
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_period = 32'd12;
        cycle();
        cfg_if.cfg_valid = 1'b0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        n_cmp++;
        if (cur_period !== DEF_P || cfg_if.cfg_ready !== 1'b1) begin
            n_err++; $display("FAIL rstpend_state got per=%0d rdy=%b exp 103/1", cur_period, cfg_if.cfg_ready);
        end
        busy = 1'b0;
        repeat (15) begin
            cycle();
            n_cmp++;
            if (obs !== expv) begin n_err++; $display("FAIL rstpend_run cyc=%0d got=%h exp=%h", cyc, obs, expv); end
            if (switch_done === 1'b1) sd_cnt++;
        end
        n_cmp++;
        if (sd_cnt != 0 || cur_period !== DEF_P) begin n_err++; $display("FAIL rstpend_noswitch got sd=%0d per=%0d exp 0/103", sd_cnt, cur_period); end
    endtask

    task automatic test_back_to_back();
        en = 1'b1; busy = 1'b0;
        repeat (150) begin
            cfg_if.cfg_valid  = 1'b1;
            cfg_if.cfg_period = 32'($urandom_range(0, 6));
            cycle();
            n_cmp++;
            if (obs !== expv) begin n_err++; $display("FAIL back_to_back cyc=%0d got=%h exp=%h", cyc, obs, expv); end
        end
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic test_random();
        repeat (3000) begin
            reset             = ($urandom_range(0, 199) == 0);
            en                = ($urandom_range(0, 9) != 0);
            busy              = ($urandom_range(0, 1) == 1);
            cfg_if.cfg_valid  = ($urandom_range(0, 4) == 0);
            cfg_if.cfg_period = 32'($urandom_range(0, 12));
            cycle();
            n_cmp++;
            if (obs !== expv) begin n_err++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, expv); end
        end
        reset = 1'b0;
        cfg_if.cfg_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_default_rate();
        test_switch_idle();
        test_busy_block();
        test_clamp();
        test_en_low();
        test_reset_pend();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
